sync_fifo_thr: RTL
==================

// Module: sync_fifo_thr
// PURPOSE
//  Single-clock, parametrised synchronous FIFO. Adds occupancy level, programmable almost-full/almost-empty
//  thresholds, synchronous flush and a read-data valid strobe. Buffers streams between LEG pipeline
//  stages and the memory/IO units. Binary pointers only; no Gray coding (single clock domain).
// PARAMETERS
//  DATA_WIDTH  32             word width in bits
//  ADDR_WIDTH  4              pointer width; depth = 2**ADDR_WIDTH (power of two only)
//  FIFO_DEPTH  1<<ADDR_WIDTH  derived, do not override
//  AF_THRESH   FIFO_DEPTH-2   almost_full_out asserted when level >= AF_THRESH
//  AE_THRESH   2              almost_empty_out asserted when level <= AE_THRESH
// PORTS
//  clk               in   1             rising-edge clock
//  rst               in   1             asynchronous, active-high reset
//  flush_in          in   1             synchronous clear of contents
//  data_in           in   DATA_WIDTH    write data
//  write_en_in       in   1             write request
//  full_out          out  1             level == FIFO_DEPTH
//  almost_full_out   out  1             level >= AF_THRESH
//  data_out          out  DATA_WIDTH    read data, registered
//  read_en_in        in   1             read request
//  valid_out         out  1             data_out updated this cycle
//  empty_out         out  1             level == 0
//  almost_empty_out  out  1             level <= AE_THRESH
//  level_out         out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  - Reset (async, any cycle): ptrs=0, level=0, data_out=0, valid_out=0 -> empty=1, almost_empty=1, full=0.
//    Memory contents are not reset.
//  - Write accepted iff write_en_in & !full_out & !flush_in. Read accepted iff read_en_in & !empty_out & !flush_in.
//  - Read latency 1: accepted read at edge N -> data_out = mem[rd_ptr], valid_out=1 after edge N.
//    Otherwise valid_out=0 and data_out holds its last value.
//  - Level: +1 write only, -1 read only, unchanged on both or neither. Held in a register; all status flags
//    are decoded from it.
//  - Simultaneous read+write: when empty, only the write is accepted. When full, only the read is accepted;
//    the write is rejected because full_out is evaluated on pre-edge level. Otherwise both accepted, level kept.
//  - Pointers are ADDR_WIDTH-bit binary and wrap FIFO_DEPTH-1 -> 0 naturally.
//  - Flush has priority over read/write: next edge ptrs=0, level=0, valid_out=0, data_out holds.
//  - Requests to read when empty or write when full are ignored silently (see CONFIGURATION).
//  - Elaboration error if AF_THRESH > FIFO_DEPTH or AE_THRESH >= FIFO_DEPTH.
// CONFIGURATION
//  - Macro FIFO_ERR_FLAGS_EN defined: adds ports overflow_out and underflow_out (1 bit each), sticky.
//    overflow_out sets on write_en_in & full_out & !flush_in. underflow_out sets on read_en_in & empty_out
//    & !flush_in. Both clear on rst or flush_in.
//  - Macro not defined: those ports and their registers do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Package fifo_pkg: level_t/ptr_t width helpers as functions of ADDR_WIDTH, FIFO_ERR_* bit indices, default
//    threshold constants.
//  - Sub-module fifo_ram: simple dual-port RAM, 1 write port, 1 registered read port (DATA_WIDTH x FIFO_DEPTH).
//    Control, pointers, level and flags stay in sync_fifo_thr.
// TESTING  (DATA_WIDTH=8, ADDR_WIDTH=2, AF_THRESH=3, AE_THRESH=1)
//  1. Reset, write 0xA1,0xA2,0xA3,0xA4 -> level 1..4; almost_full at 3; full at 4; 5th write 0xFF ignored,
//     level stays 4.
//  2. Read 4 from full -> data_out 0xA1..0xA4, one per cycle, valid_out=1 each cycle after the read;
//     empty=1 after the last; a further read gives valid_out=0 and data_out holds 0xA4.
//  3. Level 2, read+write same cycle for 8 cycles -> level stays 2, data in order, pointers wrap twice
//     with no loss.
//  4. Empty, read+write 0x5C same cycle -> write only, level=1, valid_out=0. Full, read+write -> read only,
//     level=3.
//  5. Level 3, flush_in with write_en_in=1 -> level=0, empty=1, valid_out=0 next cycle; the flushed
//     write is not stored.
//  6. Async rst pulse mid-burst between edges -> outputs reset immediately. FIFO_ERR_FLAGS_EN: write when
//     full -> overflow_out=1 until flush.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared width helpers, error-flag bit indices and default thresholds for sync_fifo_thr.
package fifo_pkg;

    localparam int FIFO_AE_THRESH_DEFAULT = 2;
    localparam int FIFO_AF_MARGIN_DEFAULT = 2;

    typedef enum int {
        FIFO_ERR_OVF = 0,
        FIFO_ERR_UDF = 1
    } fifo_err_e;

    localparam int FIFO_ERR_W = 2;

    function automatic int ptr_width(input int addr_width);
        return addr_width;
    endfunction

    // One extra bit so the level can represent a completely full FIFO.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int af_thresh_default(input int addr_width);
        return (1 << addr_width) - FIFO_AF_MARGIN_DEFAULT;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered, resettable output.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [ptr_width(ADDR_WIDTH)-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              rd_en,
    input  logic [ptr_width(ADDR_WIDTH)-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]             rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

    // NOTE: the storage array has no reset so it maps onto RAM macros; only the
    // output register is reset, which is all the FIFO's visible state needs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds, flush and read-valid strobe.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo_thr
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = af_thresh_default(ADDR_WIDTH),
    parameter int AE_THRESH  = FIFO_AE_THRESH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_in,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              write_en_in,
    output logic                              full_out,
    output logic                              almost_full_out,
    output logic [DATA_WIDTH-1:0]             data_out,
    input  logic                              read_en_in,
    output logic                              valid_out,
    output logic                              empty_out,
    output logic                              almost_empty_out,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                              overflow_out,
    output logic                              underflow_out,
`endif
    output logic [level_width(ADDR_WIDTH)-1:0] level_out
);

    localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
    localparam int LEVEL_W    = level_width(ADDR_WIDTH);
    localparam int PTR_W      = ptr_width(ADDR_WIDTH);

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [LEVEL_W-1:0] level_t;

    if (AF_THRESH > FIFO_DEPTH || AE_THRESH >= FIFO_DEPTH) begin : g_bad_thresh
        $error("sync_fifo_thr: AF_THRESH must be <= depth and AE_THRESH < depth");
    end

    ptr_t   wr_ptr_q;
    ptr_t   rd_ptr_q;
    level_t level_q;
    logic   valid_q;
    logic   wr_acc;
    logic   rd_acc;

    // Flags come from the pre-edge level, so a full FIFO rejects a concurrent write.
    assign full_out         = (level_q == level_t'(FIFO_DEPTH));
    assign empty_out        = (level_q == '0);
    assign almost_full_out  = (level_q >= level_t'(AF_THRESH));
    assign almost_empty_out = (level_q <= level_t'(AE_THRESH));
    assign level_out        = level_q;
    assign valid_out        = valid_q;

    assign wr_acc = write_en_in & ~full_out  & ~flush_in;
    assign rd_acc = read_en_in  & ~empty_out & ~flush_in;

    // NOTE: every state register uses <= so all updates see the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else if (flush_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + level_t'(1);
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - level_t'(1);
            end
            valid_q <= rd_acc;
        end
    end

    // No read/write address collision is possible: equal pointers mean empty or full.
    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic [FIFO_ERR_W-1:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (flush_in) begin
            err_q <= '0;
        end else begin
            if (write_en_in && full_out) begin
                err_q[FIFO_ERR_OVF] <= 1'b1;
            end
            if (read_en_in && empty_out) begin
                err_q[FIFO_ERR_UDF] <= 1'b1;
            end
        end
    end

    assign overflow_out  = err_q[FIFO_ERR_OVF];
    assign underflow_out = err_q[FIFO_ERR_UDF];
`endif

endmodule
